// File: rtl/tcp_test_gen.sv
// TCP traffic generator: counter/pattern byte source with rate, blocking,
// error injection, plus a 256-byte RX-to-TX loopback FIFO.
module tcp_test_gen (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  TX_RATE,
  input  logic [63:0] NUM_OF_DATA,
  input  logic        DATA_GEN,
  input  logic        LOOPBACK,
  input  logic [2:0]  WORD_LEN,
  input  logic        SELECT_SEQ,
  input  logic [31:0] SEQ_PATTERN,
  input  logic [23:0] BLK_SIZE,
  input  logic        INS_ERROR,
  input  logic        TCP_OPEN,
  output logic [15:0] TCP_RX_WC,
  input  logic        TCP_RX_WR,
  input  logic [7:0]  TCP_RX_DATA,
  input  logic        TCP_TX_FULL,
  output logic        TCP_TX_WR,
  output logic [7:0]  TCP_TX_DATA
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        dgen_q;
  logic        err_q, err_d;
  logic [63:0] cnt_q, cnt_d;
  logic [63:0] word_q, word_d;
  logic [2:0]  pos_q, pos_d;
  logic [1:0]  pat_q, pat_d;
  logic [23:0] blk_q, blk_d;
  logic [7:0]  wait_q, wait_d;

  logic [7:0]  mem_q [256];
  logic [7:0]  wr_ptr_q, wr_ptr_d;
  logic [7:0]  rd_ptr_q, rd_ptr_d;
  logic [8:0]  fcnt_q, fcnt_d;

  logic        tx_wr_q, tx_wr_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic        lb_on, start, abort, emit;
  logic        push, pop, blk_end;
  logic [2:0]  idx;
  logic [63:0] shifted;
  logic [7:0]  gen_byte;

  assign TCP_TX_WR   = tx_wr_q;
  assign TCP_TX_DATA = tx_data_q;
  assign TCP_RX_WC   = {7'd0, fcnt_q};

  always_comb begin
    lb_on = LOOPBACK & TCP_OPEN;
    start = (state_q == IDLE) & DATA_GEN & ~dgen_q & TCP_OPEN
          & ~LOOPBACK & (NUM_OF_DATA != 64'd0);
    abort = ~DATA_GEN | ~TCP_OPEN | LOOPBACK;
    emit  = (state_q == RUN) & ~abort & ~TCP_TX_FULL;
    // a live WORD_LEN shrink can leave pos past the end: treat as last byte
    idx   = (pos_q >= WORD_LEN) ? 3'd0 : WORD_LEN - pos_q;
    shifted  = word_q >> {idx, 3'b000};
    gen_byte = SELECT_SEQ ? SEQ_PATTERN[{~pat_q, 3'b000} +: 8]
                          : shifted[7:0];
    blk_end  = (BLK_SIZE != 24'd0)
             & (({1'b0, blk_q} + 25'd1) >= {1'b0, BLK_SIZE});
    push = lb_on & TCP_RX_WR & (fcnt_q != 9'd256);
    pop  = lb_on & (fcnt_q != 9'd0) & ~TCP_TX_FULL;
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q | INS_ERROR;
    cnt_d     = cnt_q;
    word_d    = word_q;
    pos_d     = pos_q;
    pat_d     = pat_q;
    blk_d     = blk_q;
    wait_d    = wait_q;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = 64'd0;
          word_d  = 64'd0;
          pos_d   = 3'd0;
          pat_d   = 2'd0;
          blk_d   = 24'd0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (emit) begin
          tx_wr_d   = 1'b1;
          tx_data_d = gen_byte ^ {7'd0, err_q | INS_ERROR};
          err_d     = 1'b0;
          cnt_d     = cnt_q + 64'd1;
          if (blk_end) begin
            word_d = 64'd0;
            pos_d  = 3'd0;
            pat_d  = 2'd0;
            blk_d  = 24'd0;
          end else begin
            blk_d = blk_q + 24'd1;
            if (SELECT_SEQ) begin
              pat_d = pat_q + 2'd1;
            end else if (pos_q >= WORD_LEN) begin
              pos_d  = 3'd0;
              word_d = word_q + 64'd1;
            end else begin
              pos_d = pos_q + 3'd1;
            end
          end
          if (cnt_d == NUM_OF_DATA) begin
            state_d = IDLE;
          end else if (TX_RATE != 8'd0) begin
            state_d = WAIT;
            wait_d  = TX_RATE - 8'd1;
          end
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (wait_q == 8'd0) begin
          state_d = RUN;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      tx_wr_d   = 1'b1;
      tx_data_d = mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (!lb_on) begin
      wr_ptr_d = 8'd0;
      rd_ptr_d = 8'd0;
      fcnt_d   = 9'd0;
    end else begin
      wr_ptr_d = wr_ptr_q + {7'd0, push};
      rd_ptr_d = rd_ptr_q + {7'd0, pop};
      fcnt_d   = fcnt_q + {8'd0, push} - {8'd0, pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= TCP_RX_DATA;
  end

  // dgen_q resets high so a level held through reset is not an edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      dgen_q    <= 1'b1;
      err_q     <= 1'b0;
      cnt_q     <= 64'd0;
      word_q    <= 64'd0;
      pos_q     <= 3'd0;
      pat_q     <= 2'd0;
      blk_q     <= 24'd0;
      wait_q    <= 8'd0;
      wr_ptr_q  <= 8'd0;
      rd_ptr_q  <= 8'd0;
      fcnt_q    <= 9'd0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      dgen_q    <= DATA_GEN;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      pos_q     <= pos_d;
      pat_q     <= pat_d;
      blk_q     <= blk_d;
      wait_q    <= wait_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_tcp_test_gen.sv
// Directed bench for tcp_test_gen: vector table of generator runs plus
// hand-written abort, back-pressure, reset and loopback sequences.
module tb_tcp_test_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_rate;
  logic [63:0] num_of_data;
  logic        data_gen;
  logic        loopback;
  logic [2:0]  word_len;
  logic        select_seq;
  logic [31:0] seq_pattern;
  logic [23:0] blk_size;
  logic        ins_error;
  logic        tcp_open;
  logic [15:0] rx_wc;
  logic        rx_wr;
  logic [7:0]  rx_data;
  logic        tx_full;
  logic        tx_wr;
  logic [7:0]  tx_data;

  tcp_test_gen dut (
    .CLK(clk), .RST(rst), .TX_RATE(tx_rate), .NUM_OF_DATA(num_of_data),
    .DATA_GEN(data_gen), .LOOPBACK(loopback), .WORD_LEN(word_len),
    .SELECT_SEQ(select_seq), .SEQ_PATTERN(seq_pattern),
    .BLK_SIZE(blk_size), .INS_ERROR(ins_error), .TCP_OPEN(tcp_open),
    .TCP_RX_WC(rx_wc), .TCP_RX_WR(rx_wr), .TCP_RX_DATA(rx_data),
    .TCP_TX_FULL(tx_full), .TCP_TX_WR(tx_wr), .TCP_TX_DATA(tx_data)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  longint      cyc = 0;
  logic        full_at_edge = 1'b0;
  logic [7:0]  q_data [$];
  longint      q_cyc [$];

  int          c_rate, c_wl, c_blk;
  bit          c_sel;
  logic [31:0] c_pat;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    full_at_edge <= tx_full;
  end

  always @(negedge clk) begin
    if (tx_wr) begin
      q_data.push_back(tx_data);
      q_cyc.push_back(cyc);
      n_chk++;
      if (full_at_edge) begin
        n_fail++;
        $display("FAIL tx_wr_while_full: tx_wr=1 data=%02h but TX_FULL was 1", tx_data);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] qd(input int i);
    if (i < q_data.size()) return q_data[i];
    return 8'hxx;
  endfunction

  function automatic logic [7:0] model(input int i);
    int     bp, nb, p;
    longint w;
    bp = (c_blk == 0) ? i : i % c_blk;
    if (c_sel) return c_pat[8 * (3 - (bp % 4)) +: 8];
    nb = c_wl + 1;
    w  = bp / nb;
    p  = bp % nb;
    return 8'((w >> (8 * (nb - 1 - p))) & 64'hff);
  endfunction

  task automatic cfg(input int rate, input int wl, input int blk,
                     input longint num, input bit sel, input logic [31:0] pat);
    c_rate = rate; c_wl = wl; c_blk = blk; c_sel = sel; c_pat = pat;
    tx_rate     = 8'(rate);
    word_len    = 3'(wl);
    blk_size    = 24'(blk);
    num_of_data = num;
    select_seq  = sel;
    seq_pattern = pat;
  endtask

  task automatic wait_bytes(input string nm, input int n, input int budget);
    for (int i = 0; i < budget && q_data.size() < n; i++) step(1);
    chk(nm, 64'(q_data.size() >= n), 64'd1);
  endtask

  task automatic seq_check(input string nm, input bit gaps);
    int nmis, ngap;
    nmis = 0; ngap = 0;
    foreach (q_data[i]) if (q_data[i] !== model(i)) nmis++;
    chk({nm, "_seq_mismatches"}, 64'(nmis), 64'd0);
    if (gaps) begin
      for (int i = 1; i < q_cyc.size(); i++)
        if (q_cyc[i] - q_cyc[i-1] != longint'(c_rate + 1)) ngap++;
      chk({nm, "_spacing_errors"}, 64'(ngap), 64'd0);
    end
  endtask

  task automatic do_run(input string nm, input int exp_n, input int budget);
    q_data.delete(); q_cyc.delete();
    data_gen = 1'b1;
    for (int i = 0; i < budget && q_data.size() < exp_n; i++) step(1);
    step(20);
    data_gen = 1'b0;
    step(3);
    chk({nm, "_count"}, 64'(q_data.size()), 64'(exp_n));
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_wr = 1'b1; rx_data = b;
    step(1);
    rx_wr = 1'b0;
  endtask

  typedef struct {
    int          rate;
    int          wl;
    int          blk;
    int          num;
    bit          sel;
    logic [31:0] pat;
    logic [63:0] ebytes;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n0, nmis;
    logic [7:0] diffx;

    vecs[0] = '{0, 3, 0, 6,   1'b1, 32'h6080_8040, 64'h6080_8040_6080_0000};
    vecs[1] = '{0, 1, 0, 8,   1'b0, 32'h0,         64'h0000_0001_0002_0003};
    vecs[2] = '{2, 0, 3, 8,   1'b0, 32'h0,         64'h0001_0200_0102_0001};
    vecs[3] = '{0, 0, 0, 260, 1'b0, 32'h0,         64'h0001_0203_0405_0607};
    vecs[4] = '{3, 0, 0, 0,   1'b0, 32'h0,         64'h0};
    vecs[5] = '{1, 0, 3, 7,   1'b1, 32'hA1B2_C3D4, 64'hA1B2_C3A1_B2C3_A100};

    rst = 1'b1; data_gen = 1'b0; loopback = 1'b0; ins_error = 1'b0;
    tcp_open = 1'b1; rx_wr = 1'b0; rx_data = 8'd0; tx_full = 1'b0;
    cfg(0, 0, 0, 0, 1'b0, 32'h0);
    step(3);
    @(negedge clk);
    chk("reset_tx_wr", 64'(tx_wr), 64'd0);
    chk("reset_tx_data", 64'(tx_data), 64'd0);
    chk("reset_rx_wc", 64'(rx_wc), 64'd0);
    step(1);
    rst = 1'b0;
    step(2);

    for (int v = 0; v < 6; v++) begin
      cfg(vecs[v].rate, vecs[v].wl, vecs[v].blk, 64'(vecs[v].num),
          vecs[v].sel, vecs[v].pat);
      do_run($sformatf("vec%0d", v), vecs[v].num,
             vecs[v].num * (vecs[v].rate + 1) + 50);
      for (int b = 0; b < 8 && b < vecs[v].num; b++)
        chk($sformatf("vec%0d_byte%0d", v, b), 64'(qd(b)),
            64'(vecs[v].ebytes[63 - 8 * b -: 8]));
      seq_check($sformatf("vec%0d", v), 1'b1);
    end

    // error request while idle hits the first byte of the next run
    cfg(0, 0, 0, 4, 1'b0, 32'h0);
    ins_error = 1'b1; step(1); ins_error = 1'b0; step(3);
    do_run("idle_err", 4, 60);
    chk("idle_err_b0", 64'(qd(0)), 64'h01);
    chk("idle_err_b1", 64'(qd(1)), 64'h01);
    chk("idle_err_b3", 64'(qd(3)), 64'h03);

    // long counter run with 64-byte blocks
    cfg(5, 7, 64, 256, 1'b0, 32'h0);
    do_run("long", 256, 256 * 6 + 100);
    chk("long_b0", 64'(qd(0)), 64'h00);
    chk("long_b7", 64'(qd(7)), 64'h00);
    chk("long_b15", 64'(qd(15)), 64'h01);
    chk("long_b63", 64'(qd(63)), 64'h07);
    chk("long_b64", 64'(qd(64)), 64'h00);
    chk("long_b71", 64'(qd(71)), 64'h00);
    chk("long_b79", 64'(qd(79)), 64'h01);
    chk("long_b255", 64'(qd(255)), 64'h07);
    seq_check("long", 1'b1);

    // same run with a mid-run error pulse
    q_data.delete(); q_cyc.delete();
    data_gen = 1'b1;
    wait_bytes("err_wait100", 100, 1000);
    ins_error = 1'b1; step(1); ins_error = 1'b0;
    wait_bytes("err_wait256", 256, 1200);
    step(20);
    data_gen = 1'b0; step(3);
    chk("err_count", 64'(q_data.size()), 64'd256);
    nmis = 0; diffx = 8'd0;
    foreach (q_data[i]) begin
      if (q_data[i] !== model(i)) nmis++;
      diffx = diffx | (q_data[i] ^ model(i));
    end
    chk("err_one_byte_differs", 64'(nmis), 64'd1);
    chk("err_xor_bit0", 64'(diffx), 64'h01);

    // back-pressure hold of 10 cycles
    cfg(0, 0, 0, 40, 1'b0, 32'h0);
    q_data.delete(); q_cyc.delete();
    data_gen = 1'b1;
    wait_bytes("full_wait10", 10, 100);
    tx_full = 1'b1;
    n0 = q_data.size();
    step(10);
    chk("full_hold_no_wr", 64'(q_data.size()), 64'(n0 + 1));
    tx_full = 1'b0;
    wait_bytes("full_wait40", 40, 100);
    step(10);
    data_gen = 1'b0; step(3);
    chk("full_count", 64'(q_data.size()), 64'd40);
    seq_check("full", 1'b0);

    // DATA_GEN abort
    cfg(0, 0, 0, 100, 1'b0, 32'h0);
    q_data.delete(); q_cyc.delete();
    data_gen = 1'b1;
    wait_bytes("dg_wait", 10, 100);
    data_gen = 1'b0;
    n0 = q_data.size();
    step(5);
    chk("dg_abort_stop", 64'(q_data.size()), 64'(n0 + 1));
    @(negedge clk);
    chk("dg_abort_wr", 64'(tx_wr), 64'd0);
    seq_check("dg_abort", 1'b1);

    // TCP_OPEN abort; reopening without a new edge stays idle
    step(1);
    q_data.delete(); q_cyc.delete();
    data_gen = 1'b1;
    wait_bytes("open_wait", 10, 100);
    tcp_open = 1'b0;
    n0 = q_data.size();
    step(5);
    chk("open_abort_stop", 64'(q_data.size()), 64'(n0 + 1));
    tcp_open = 1'b1;
    step(10);
    chk("open_no_restart", 64'(q_data.size()), 64'(n0 + 1));
    data_gen = 1'b0; step(2);

    // reset mid-run
    q_data.delete(); q_cyc.delete();
    data_gen = 1'b1;
    wait_bytes("rst_wait", 10, 100);
    rst = 1'b1;
    step(2);
    @(negedge clk);
    chk("rst_tx_wr", 64'(tx_wr), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_rx_wc", 64'(rx_wc), 64'd0);
    step(1);
    rst = 1'b0;
    n0 = q_data.size();
    step(10);
    chk("rst_no_restart", 64'(q_data.size()), 64'(n0));
    data_gen = 1'b0; step(2);

    // loopback echo of three bytes
    loopback = 1'b1; tx_full = 1'b1; step(2);
    q_data.delete(); q_cyc.delete();
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33);
    step(1);
    @(negedge clk);
    chk("lb_wc3", 64'(rx_wc), 64'd3);
    chk("lb_held", 64'(q_data.size()), 64'd0);
    step(1);
    tx_full = 1'b0;
    step(10);
    chk("lb_echo_count", 64'(q_data.size()), 64'd3);
    chk("lb_echo0", 64'(qd(0)), 64'h11);
    chk("lb_echo1", 64'(qd(1)), 64'h22);
    chk("lb_echo2", 64'(qd(2)), 64'h33);
    @(negedge clk);
    chk("lb_wc0", 64'(rx_wc), 64'd0);

    // fill to 256, 257th byte dropped
    step(1);
    tx_full = 1'b1; step(1);
    q_data.delete(); q_cyc.delete();
    rx_wr = 1'b1;
    for (int i = 0; i < 257; i++) begin
      rx_data = 8'(i);
      step(1);
    end
    rx_wr = 1'b0;
    step(1);
    @(negedge clk);
    chk("lb_full_wc", 64'(rx_wc), 64'd256);
    step(1);
    tx_full = 1'b0;
    step(270);
    chk("lb_full_count", 64'(q_data.size()), 64'd256);
    nmis = 0;
    foreach (q_data[i]) if (q_data[i] !== 8'(i)) nmis++;
    chk("lb_full_order", 64'(nmis), 64'd0);

    // flush on LOOPBACK=0 and RX ignored while off
    tx_full = 1'b1;
    for (int i = 0; i < 5; i++) rx_push(8'(i + 1));
    loopback = 1'b0;
    step(2);
    @(negedge clk);
    chk("lb_flush_wc", 64'(rx_wc), 64'd0);
    step(1);
    rx_push(8'h55); rx_push(8'h66);
    @(negedge clk);
    chk("lb_off_ignore_wc", 64'(rx_wc), 64'd0);
    step(1);
    loopback = 1'b1; tx_full = 1'b0;
    q_data.delete(); q_cyc.delete();
    step(10);
    chk("lb_flush_empty", 64'(q_data.size()), 64'd0);

    // streaming push and pop together
    rx_wr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_data = 8'(8'h40 + i);
      step(1);
    end
    rx_wr = 1'b0;
    @(negedge clk);
    chk("lb_stream_wc", 64'(rx_wc), 64'd1);
    step(5);
    chk("lb_stream_count", 64'(q_data.size()), 64'd20);
    nmis = 0;
    foreach (q_data[i]) if (q_data[i] !== 8'(8'h40 + i)) nmis++;
    chk("lb_stream_order", 64'(nmis), 64'd0);
    @(negedge clk);
    chk("lb_stream_wc0", 64'(rx_wc), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
